// File: rtl/ex_muldiv_hilo_if.sv
// ex_muldiv_hilo_if: EX-stage operand/result bundle between the ID/EX register, the HI/LO unit and the EX result mux
interface ex_muldiv_hilo_if #(parameter int ANCHO = 32);
    logic             valido_EX;
    logic [1:0]       alu_operacion_EX;
    logic [5:0]       funct_EX;
    logic [ANCHO-1:0] dr1_EX;
    logic [ANCHO-1:0] dr2_EX;
    logic [ANCHO-1:0] hi;
    logic [ANCHO-1:0] lo;
    logic [ANCHO-1:0] resultado_mf;
    logic             es_mf;
    logic             ocupado;
    logic             detener;
    logic             listo;
    modport master (
        output valido_EX, alu_operacion_EX, funct_EX, dr1_EX, dr2_EX,
        input  hi, lo, resultado_mf, es_mf, ocupado, detener, listo
    );
    modport slave (
        input  valido_EX, alu_operacion_EX, funct_EX, dr1_EX, dr2_EX,
        output hi, lo, resultado_mf, es_mf, ocupado, detener, listo
    );
endinterface

// File: rtl/ex_muldiv_hilo.sv
// ex_muldiv_hilo: iterative MULT/DIV unit owning HI/LO; MULDIV_CERO_RAPIDO_EN finishes zero-operand ops early
module ex_muldiv_hilo #(parameter int ANCHO = 32) (
    input logic             clk,
    input logic             reset,
    ex_muldiv_hilo_if.slave bus
);
    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);
    typedef enum logic [1:0] {INACTIVO, CALC, AJUSTE} estado_t;
    estado_t            estado;
    logic [CW-1:0]      contador;
    logic [2*ANCHO-1:0] acc, acc_mul, acc_div, prod;
    logic [ANCHO-1:0]   b, q, r, mag1, mag2, hi_r, lo_r;
    logic [ANCHO:0]     suma, resta;
    logic               es_div, neg_q, neg_r, listo_r;
    logic               op_ok, es_md, es_conocida, s1, s2, div_cero;
    always_comb begin
        op_ok       = bus.valido_EX && bus.alu_operacion_EX == 2'b10;
        es_md       = op_ok && bus.funct_EX[5:2] == 4'b0110;
        es_conocida = op_ok && bus.funct_EX[5:4] == 2'b01 && !bus.funct_EX[2];
        s1          = !bus.funct_EX[0] && bus.dr1_EX[ANCHO-1];
        s2          = !bus.funct_EX[0] && bus.dr2_EX[ANCHO-1];
        mag1        = s1 ? -bus.dr1_EX : bus.dr1_EX;
        mag2        = s2 ? -bus.dr2_EX : bus.dr2_EX;
        div_cero    = bus.funct_EX[1] && bus.dr2_EX == '0;
        // multiply: low half starts as the multiplier and shifts out as the product shifts in
        suma        = {1'b0, acc[2*ANCHO-1:ANCHO]} + (acc[0] ? {1'b0, b} : '0);
        acc_mul     = {suma, acc[ANCHO-1:1]};
        // restoring divide: upper half is the partial remainder, low half collects quotient bits
        resta       = acc[2*ANCHO-1:ANCHO-1] - {1'b0, b};
        acc_div     = resta[ANCHO] ? {acc[2*ANCHO-2:0], 1'b0}
                                   : {resta[ANCHO-1:0], acc[ANCHO-2:0], 1'b1};
        prod        = neg_q ? -acc : acc;
        q           = neg_q ? -acc[ANCHO-1:0] : acc[ANCHO-1:0];
        r           = neg_r ? -acc[2*ANCHO-1:ANCHO] : acc[2*ANCHO-1:ANCHO];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado   <= INACTIVO;
            contador <= '0;
            acc      <= '0;
            b        <= '0;
            es_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            listo_r  <= 1'b0;
        end else begin
            listo_r <= 1'b0;
            case (estado)
                INACTIVO: begin
                    if (es_md) begin
                        es_div   <= bus.funct_EX[1];
                        neg_q    <= (s1 ^ s2) && !div_cero;
                        neg_r    <= s1;
                        b        <= bus.funct_EX[1] ? mag2 : mag1;
                        acc      <= {{ANCHO{1'b0}}, bus.funct_EX[1] ? mag1 : mag2};
                        contador <= '0;
                        estado   <= CALC;
`ifdef MULDIV_CERO_RAPIDO_EN
                        if (div_cero || (!bus.funct_EX[1] && (bus.dr1_EX == '0 || bus.dr2_EX == '0))) begin
                            acc     <= div_cero ? {mag1, {ANCHO{1'b1}}} : '0;
                            estado  <= AJUSTE;
                            listo_r <= 1'b1;
                        end
`endif
                    end else if (op_ok && bus.funct_EX == 6'h11) begin
                        hi_r <= bus.dr1_EX;
                    end else if (op_ok && bus.funct_EX == 6'h13) begin
                        lo_r <= bus.dr1_EX;
                    end
                end
                CALC: begin
                    acc      <= es_div ? acc_div : acc_mul;
                    contador <= contador + 1'b1;
                    if (contador == ULTIMO) begin
                        estado  <= AJUSTE;
                        listo_r <= 1'b1;
                    end
                end
                AJUSTE: begin
                    hi_r   <= es_div ? r : prod[2*ANCHO-1:ANCHO];
                    lo_r   <= es_div ? q : prod[ANCHO-1:0];
                    estado <= INACTIVO;
                end
                default: estado <= INACTIVO;
            endcase
        end
    end
    assign bus.hi           = hi_r;
    assign bus.lo           = lo_r;
    assign bus.listo        = listo_r;
    assign bus.ocupado      = estado != INACTIVO;
    assign bus.detener      = bus.ocupado && es_conocida;
    assign bus.es_mf        = op_ok && (bus.funct_EX == 6'h10 || bus.funct_EX == 6'h12);
    assign bus.resultado_mf = !op_ok ? '0 : bus.funct_EX == 6'h10 ? hi_r : bus.funct_EX == 6'h12 ? lo_r : '0;
endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// tb_ex_muldiv_hilo: directed vectors and hand sequences for the HI/LO mul/div unit
module tb_ex_muldiv_hilo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n;
    ex_muldiv_hilo_if #(.ANCHO(32)) bus ();
    ex_muldiv_hilo #(.ANCHO(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          z;
    } vec_t;
    vec_t v [11];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.valido_EX = 1'b1;
        bus.alu_operacion_EX = 2'b10;
        bus.funct_EX = f;
        bus.dr1_EX = a;
        bus.dr2_EX = b;
    endtask
    task automatic bubble;
        bus.valido_EX = 1'b0;
        bus.funct_EX = 6'h00;
    endtask
    initial begin
        int exp_lat;
        v[0]  = '{6'h18, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        v[1]  = '{6'h1B, 32'd100,        32'd7,        32'd2,        32'd14,       1'b0};
        v[2]  = '{6'h1A, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        v[3]  = '{6'h19, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        v[4]  = '{6'h1B, 32'd9,          32'd0,        32'd9,        32'hFFFFFFFF, 1'b1};
        v[5]  = '{6'h1A, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        v[6]  = '{6'h1A, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        v[7]  = '{6'h18, 32'h00010000,   32'h00010000, 32'd1,        32'd0,        1'b0};
        v[8]  = '{6'h1A, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        v[9]  = '{6'h18, 32'd0,          32'd5,        32'd0,        32'd0,        1'b1};
        v[10] = '{6'h1B, 32'hFFFFFFFF,   32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};
        bubble();
        bus.alu_operacion_EX = 2'b00;
        bus.dr1_EX = '0;
        bus.dr2_EX = '0;
        step();
        step();
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_listo", 32'(bus.listo), 32'd0);
        chk("rst_detener", 32'(bus.detener), 32'd0);
        reset = 1'b1;
        step();
        // reset in the middle of an iteration
        issue(6'h18, 32'd5, 32'd5);
        step();
        bubble();
        repeat (5) step();
        chk("midcalc_ocupado", 32'(bus.ocupado), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        step();
        reset = 1'b1;
        repeat (40) step();
        chk("post_rst_lo", bus.lo, 32'd0);
        chk("post_rst_listo", 32'(bus.listo), 32'd0);
        issue(6'h12, 32'd0, 32'd0);
        #1;
        chk("post_rst_mflo", bus.resultado_mf, 32'd0);
        chk("post_rst_es_mf", 32'(bus.es_mf), 32'd1);
        step();
        // MTLO while idle
        issue(6'h13, 32'h1234, 32'd0);
        #1;
        chk("mtlo_detener", 32'(bus.detener), 32'd0);
        step();
        bubble();
        chk("mtlo_lo", bus.lo, 32'h1234);
        for (int i = 0; i < 11; i++) begin
`ifdef MULDIV_CERO_RAPIDO_EN
            exp_lat = v[i].z ? 1 : 33;
`else
            exp_lat = 33;
`endif
            issue(v[i].f, v[i].a, v[i].b);
            step();
            bubble();
            n = 1;
            while (!bus.listo && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("lat%0d", i), n, exp_lat);
            step();
            chk($sformatf("hi%0d", i), bus.hi, v[i].hi);
            chk($sformatf("lo%0d", i), bus.lo, v[i].lo);
            chk($sformatf("listo_drop%0d", i), 32'(bus.listo), 32'd0);
        end
        // MULTU then a stalled MFHI
        issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        issue(6'h10, 32'd0, 32'd0);
        #1;
        chk("stall_es_mf", 32'(bus.es_mf), 32'd1);
        n = 0;
        while (bus.detener && n < 50) begin
            n++;
            step();
        end
        chk("mfhi_stall_cycles", n, 32'd33);
        chk("mfhi_value", bus.resultado_mf, 32'hFFFFFFFE);
        issue(6'h12, 32'd0, 32'd0);
        #1;
        chk("mflo_value", bus.resultado_mf, 32'h00000001);
        step();
        // MTHI held behind a busy DIVU
        issue(6'h1B, 32'd100, 32'd7);
        step();
        issue(6'h11, 32'hABCD, 32'd0);
        repeat (3) step();
        chk("mthi_held_detener", 32'(bus.detener), 32'd1);
        chk("mthi_held_hi", bus.hi, 32'hFFFFFFFE);
        n = 0;
        while (bus.detener && n < 50) begin
            n++;
            step();
        end
        chk("div_rem_hi", bus.hi, 32'd2);
        step();
        bubble();
        chk("mthi_hi", bus.hi, 32'hABCD);
        chk("mthi_lo_kept", bus.lo, 32'd14);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_hilo.md
Name: ex_muldiv_hilo

Overview:
- EX-stage consumer of the ID/EX pipeline register outputs.
- Executes MIPS R-type MULT/MULTU/DIV/DIVU iteratively and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request toward the ID/EX and IF/ID buffers while a result is pending.

Parameters:
- ANCHO, 32, operand/HI/LO width in bits; iteration count equals ANCHO.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valido_EX  input  1  EX holds a real instruction (0 = bubble).
- alu_operacion_EX  input  2  from ID/EX; 2'b10 = R-type.
- funct_EX  input  6  from ID/EX funct field.
- dr1_EX  input  ANCHO  rs value (dividend / multiplicand / MT source).
- dr2_EX  input  ANCHO  rt value (divisor / multiplier).
- hi  output  ANCHO  HI register.
- lo  output  ANCHO  LO register.
- resultado_mf  output  ANCHO  MFHI/MFLO read data to EX result mux.
- es_mf  output  1  EX instruction is MFHI/MFLO; selects resultado_mf.
- ocupado  output  1  iteration in progress.
- detener  output  1  combinational stall request to ID/EX and earlier stages.
- listo  output  1  one-cycle pulse when HI/LO take a new mul/div result.

Behaviour:
- Decode: op valid only if valido_EX=1 and alu_operacion_EX=2'b10.
  - funct 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - funct 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
  - Other funct: no effect.
- Reset (reset=0, async): estado=INACTIVO; hi=lo=0; internal accumulators 0; ocupado=0; listo=0.
  - detener and es_mf follow their combinational equations (0 when valido_EX=0).
  - An operation in flight is discarded and HI/LO do not change.
- FSM INACTIVO:
  - On mul/div op, latch the operand magnitudes (signed ops take abs value), the result sign flags and the op type; go to CALC with contador=0.
  - MTHI/MTLO write hi/lo from dr1_EX at the same edge.
- FSM CALC, one iteration per clock:
  - Multiply: shift-add on a 2*ANCHO product.
  - Divide: restoring, one quotient bit per cycle.
  - At contador=ANCHO-1, go to AJUSTE.
- FSM AJUSTE:
  - Apply signs. Signed multiply: negate the full 2*ANCHO product if signs differ.
  - Signed divide: quotient is negative if signs differ; remainder takes the dividend's sign (truncating division).
  - Load hi (product high / remainder) and lo (product low / quotient).
  - Pulse listo for this cycle; return to INACTIVO.
- Latency: op accepted at edge N; hi/lo valid after edge N+ANCHO+1. ocupado=1 from N+1 through N+ANCHO+1 (estado!=INACTIVO).
- detener = ocupado AND (EX op is any of the 8 funct codes above).
  - The stall holds the instruction in EX. A held mul/div is not re-accepted until INACTIVO.
  - A held MF op reads the final value once detener drops.
  - The cycle after listo, a held mul/div is accepted as new.
- resultado_mf = hi for MFHI, lo for MFLO, 0 otherwise (combinational). es_mf is independent of detener.
- Divide by zero (dr2_EX=0): runs the full latency; lo = all ones, hi = dividend (signed: original signed dividend). No trap.
- Signed most-negative / -1: lo = 0x80000000, hi = 0.
- MTHI/MTLO while ocupado: stalled, never written mid-operation.

Optional Feature:
- Macro MULDIV_CERO_RAPIDO_EN.
- Defined: if either multiply operand is 0 at accept, skip CALC and go straight to AJUSTE.
  - Result hi=lo=0 after edge N+1; listo at cycle N+1.
  - Divide by zero also completes early with the values above.
- Undefined: every op takes the full ANCHO+1 cycles.

Test Plan:
- Reset low mid-CALC of MULT 5*5:
  - hi/lo stay 0 (from the earlier reset), ocupado=0 immediately.
  - After release, MFLO returns 0.
- MULT dr1=7, dr2=0xFFFFFFFD (-3):
  - listo exactly 33 cycles after accept.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF followed by MFHI:
  - detener=1 for 33 cycles, then resultado_mf=0xFFFFFFFE.
  - MFLO then returns 0x00000001.
- DIVU 9/0 -> lo=0xFFFFFFFF, hi=9.
  - With MULDIV_CERO_RAPIDO_EN: listo 1 cycle after accept.
  - Without it: 33 cycles.
- MTLO 0x1234 in idle:
  - lo=0x1234 next cycle, detener=0.
  - MTHI issued during a busy DIV is stalled; hi equals the DIV remainder, then the MTHI value.
